// File: rtl/mux_4x1_rr_ctrl.sv
// Round-robin select controller in front of a 4:1 mux: grants one requester,
// holds the selects for SETTLE cycles, captures mux_y and hands it downstream.
module mux_4x1_rr_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mux_y,
    output logic       s0,
    output logic       s1,
    output logic [3:0] ack,
    output logic       out_bit,
    output logic [1:0] out_ch,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] ack_q, ack_d;
    logic       out_bit_q, out_bit_d;
    logic [1:0] out_ch_q, out_ch_d;
    logic       out_valid_q, out_valid_d;

    logic [1:0] grant_ch;
    logic [1:0] scan_idx;
    logic       grant_found;

    // First pending requester at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        grant_ch    = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!grant_found && req[scan_idx]) begin
                grant_ch    = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        ack_d       = '0;
        out_bit_d   = out_bit_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    sel_d   = grant_ch;
                    cnt_d   = 4'(SETTLE - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_bit_d   = mux_y;
                    out_ch_d    = sel_q;
                    out_valid_d = 1'b1;
                    ack_d       = 4'b0001 << sel_q;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = sel_q + 2'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            ack_q       <= '0;
            out_bit_q   <= 1'b0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            out_bit_q   <= out_bit_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign ack       = ack_q;
    assign out_bit   = out_bit_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
